mac_tx_store_fwd_gate: RTL and testbench

- Sits directly downstream of the engine TX port and feeds the MAC TX side (val/data/last/padbytes interface).
- Converts the engine's startframe/endframe/frame_size stream into a last-terminated MAC stream.
- Operates store-and-forward, so the MAC never underruns mid-frame.
- Validates each frame's byte length against its advertised frame_size and drops malformed or oversize frames.

---
 rtl/mac_tx_store_fwd_gate.sv | 224 ++++++++++++++++++++++
 tb/tb_mac_tx_store_fwd_gate.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_store_fwd_gate.sv
// Store-and-forward gate between the engine TX port and the MAC TX stream.
// Frames are buffered speculatively and released to the MAC only after their length checks out.
module mac_tx_store_fwd_gate #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned PADBYTES_W = 6,
  parameter int unsigned SIZE_W     = 16,
  parameter int unsigned LOG2_ELS   = 6,
  parameter int unsigned MAX_BEATS  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_val,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_startframe,
  input  logic [SIZE_W-1:0]     in_frame_size,
  input  logic                  in_endframe,
  input  logic [PADBYTES_W-1:0] in_padbytes,
  output logic                  in_rdy,
  output logic                  out_val,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [PADBYTES_W-1:0] out_padbytes,
  input  logic                  out_rdy,
  output logic                  err_len,
  output logic                  err_oversize
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << LOG2_ELS;
  localparam int unsigned PTR_W = LOG2_ELS + 1;
  localparam int unsigned LEN_W = SIZE_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 2);

  localparam logic [PTR_W-1:0] FULL_USED = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic                  last;
    logic [PADBYTES_W-1:0] pad;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } state_t;

  entry_t mem [DEPTH];

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]    commit_ptr, commit_nxt;
  logic [PTR_W-1:0]    rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]    frame_start, frame_start_nxt;
  logic [SIZE_W-1:0]   size_q, size_nxt;
  logic [CNT_W-1:0]    beat_cnt, cnt_nxt, cnt_inc;
  logic [LEN_W-1:0]    len_frame, len_single;
  logic [PTR_W-1:0]    wr_addr, start_base, rd_next_addr;
  logic                accept, full, we, start_now;
  logic                err_len_nxt, err_ovs_nxt, in_rdy_nxt;
  logic                pop, load;
  entry_t              rd_entry;

  assign accept = in_val & in_rdy;
  assign full   = (wr_ptr - rd_ptr) == FULL_USED;

  // rd_ptr tracks the beat held in the output register, so that beat still counts as occupied.
  assign rd_next_addr = out_val ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign pop          = out_val & out_rdy;
  assign load         = (~out_val | out_rdy) & (rd_next_addr != commit_ptr);
  assign rd_ptr_nxt   = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign rd_entry     = mem[rd_next_addr[LOG2_ELS-1:0]];

  // Write FSM: speculative write, then commit or rewind at frame end.
  always_comb begin
    state_nxt       = state;
    wr_ptr_nxt      = wr_ptr;
    commit_nxt      = commit_ptr;
    frame_start_nxt = frame_start;
    size_nxt        = size_q;
    cnt_nxt         = beat_cnt;
    we              = 1'b0;
    wr_addr         = wr_ptr;
    err_len_nxt     = 1'b0;
    err_ovs_nxt     = 1'b0;
    start_now       = 1'b0;
    start_base      = wr_ptr;
    cnt_inc         = beat_cnt + CNT_W'(1);
    len_frame       = LEN_W'(cnt_inc) * LEN_W'(BYTES) - LEN_W'(in_padbytes);
    len_single      = LEN_W'(BYTES) - LEN_W'(in_padbytes);

    if (accept) begin
      case (state)
        FRAME: begin
          if (in_startframe) begin
            // Truncated frame: discard it and restart in place with the new frame.
            err_len_nxt = 1'b1;
            start_now   = 1'b1;
            start_base  = frame_start;
          end else if (beat_cnt == CNT_W'(MAX_BEATS)) begin
            wr_ptr_nxt  = frame_start;
            err_ovs_nxt = 1'b1;
            state_nxt   = in_endframe ? IDLE : DROP;
          end else begin
            we         = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            cnt_nxt    = cnt_inc;
            if (in_endframe) begin
              state_nxt = IDLE;
              if (len_frame == LEN_W'(size_q)) begin
                commit_nxt = wr_ptr + PTR_ONE;
              end else begin
                wr_ptr_nxt  = frame_start;
                err_len_nxt = 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (in_startframe) begin
            start_now = 1'b1;
          end else if (in_endframe) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          if (in_startframe) begin
            start_now = 1'b1;
          end else begin
            err_len_nxt = 1'b1;
          end
        end
      endcase

      if (start_now) begin
        if (state == DROP && full) begin
          // No room for the new frame while draining a dropped one; lose it too.
          err_len_nxt = 1'b1;
          state_nxt   = in_endframe ? IDLE : DROP;
        end else begin
          we              = 1'b1;
          wr_addr         = start_base;
          frame_start_nxt = start_base;
          size_nxt        = in_frame_size;
          cnt_nxt         = CNT_W'(1);
          if (in_endframe) begin
            state_nxt = IDLE;
            if (len_single == LEN_W'(in_frame_size)) begin
              wr_ptr_nxt = start_base + PTR_ONE;
              commit_nxt = start_base + PTR_ONE;
            end else begin
              wr_ptr_nxt  = start_base;
              err_len_nxt = 1'b1;
            end
          end else begin
            wr_ptr_nxt = start_base + PTR_ONE;
            state_nxt  = FRAME;
          end
        end
      end
    end

    in_rdy_nxt = (state_nxt == DROP) | ((wr_ptr_nxt - rd_ptr_nxt) != FULL_USED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      frame_start  <= '0;
      size_q       <= '0;
      beat_cnt     <= '0;
      in_rdy       <= 1'b0;
      err_len      <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      commit_ptr   <= commit_nxt;
      frame_start  <= frame_start_nxt;
      size_q       <= size_nxt;
      beat_cnt     <= cnt_nxt;
      in_rdy       <= in_rdy_nxt;
      err_len      <= err_len_nxt;
      err_oversize <= err_ovs_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr[LOG2_ELS-1:0]] <= '{
        data: in_data,
        last: in_endframe,
        pad:  in_endframe ? in_padbytes : '0
      };
    end
  end

  // Output register: refills in the same cycle it is consumed for full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      out_val      <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_padbytes <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (load) begin
        out_val      <= 1'b1;
        out_data     <= rd_entry.data;
        out_last     <= rd_entry.last;
        out_padbytes <= rd_entry.pad;
      end else if (out_rdy) begin
        out_val      <= 1'b0;
        out_last     <= 1'b0;
        out_padbytes <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_tx_store_fwd_gate.sv
// Bench for mac_tx_store_fwd_gate: frame table, hand-written corner sequences and random traffic
// checked against a frame-level queue model of the gate.
module tb_mac_tx_store_fwd_gate;

  localparam int DATA_W     = 512;
  localparam int PADBYTES_W = 6;
  localparam int SIZE_W     = 16;
  localparam int BYTES      = DATA_W / 8;
  localparam int MAX_BEATS  = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_val = 1'b0;
  logic [DATA_W-1:0]     in_data = '0;
  logic                  in_startframe = 1'b0;
  logic [SIZE_W-1:0]     in_frame_size = '0;
  logic                  in_endframe = 1'b0;
  logic [PADBYTES_W-1:0] in_padbytes = '0;
  logic                  in_rdy;
  logic                  out_val;
  logic [DATA_W-1:0]     out_data;
  logic                  out_last;
  logic [PADBYTES_W-1:0] out_padbytes;
  logic                  out_rdy = 1'b0;
  logic                  err_len;
  logic                  err_oversize;

  mac_tx_store_fwd_gate dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_val       (in_val),
    .in_data      (in_data),
    .in_startframe(in_startframe),
    .in_frame_size(in_frame_size),
    .in_endframe  (in_endframe),
    .in_padbytes  (in_padbytes),
    .in_rdy       (in_rdy),
    .out_val      (out_val),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_padbytes (out_padbytes),
    .out_rdy      (out_rdy),
    .err_len      (err_len),
    .err_oversize (err_oversize)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0]     data;
    logic                  last;
    logic [PADBYTES_W-1:0] pad;
  } beat_t;

  typedef struct {
    int    nb;
    bit    no_sof;
    int    size;
    int    pad;
    int    e_out;
    int    e_el;
    int    e_eo;
    string name;
  } row_t;

  int    tests = 0;
  int    fails = 0;
  int    n_out = 0;
  int    dut_el = 0;
  int    dut_eo = 0;
  int    exp_el = 0;
  int    exp_eo = 0;
  bit    rnd_out = 1'b0;

  beat_t exp_q[$];
  beat_t cur_q[$];
  bit    m_in_frame = 1'b0;
  bit    m_drop = 1'b0;
  int    m_size = 0;

  bit                    hold_prev = 1'b0;
  logic [DATA_W-1:0]     hold_data;
  logic                  hold_last;
  logic [PADBYTES_W-1:0] hold_pad;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Frame-level reference: a frame reaches the MAC only if complete, within MAX_BEATS and
  // its byte count beats*BYTES-padbytes equals the size given with startframe.
  task automatic model_beat(input logic sof, input logic eof, input logic [SIZE_W-1:0] fsz,
                            input logic [PADBYTES_W-1:0] pad, input logic [DATA_W-1:0] d);
    beat_t b;
    bit    el;
    bit    done;
    int    len;
    el     = 1'b0;
    done   = 1'b0;
    b.data = d;
    b.last = eof;
    b.pad  = eof ? pad : '0;
    if (m_in_frame && !sof) begin
      if (cur_q.size() == MAX_BEATS) begin
        exp_eo++;
        cur_q.delete();
        m_in_frame = 1'b0;
        m_drop     = !eof;
      end else begin
        cur_q.push_back(b);
        done = eof;
      end
    end else if (sof) begin
      if (m_in_frame) el = 1'b1;
      cur_q.delete();
      m_drop     = 1'b0;
      m_in_frame = 1'b1;
      m_size     = int'(fsz);
      cur_q.push_back(b);
      done = eof;
    end else if (m_drop) begin
      if (eof) m_drop = 1'b0;
    end else begin
      el = 1'b1;
    end
    if (done) begin
      len = cur_q.size() * BYTES - int'(pad);
      if (len == m_size) begin
        foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
      end else begin
        el = 1'b1;
      end
      cur_q.delete();
      m_in_frame = 1'b0;
    end
    if (el) exp_el++;
  endtask

  // Monitor: sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur_q.delete();
      m_in_frame = 1'b0;
      m_drop     = 1'b0;
      hold_prev  = 1'b0;
    end else begin
      if (hold_prev) begin
        check(out_val && out_data == hold_data && out_last == hold_last && out_padbytes == hold_pad,
              "hold_stable", longint'(out_data[31:0]), longint'(hold_data[31:0]));
      end
      if (out_val && out_rdy) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", longint'(out_data[31:0]), 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check(out_data == e.data && out_last == e.last && out_padbytes == e.pad, "out_beat",
                longint'({out_last, out_padbytes, out_data[23:0]}),
                longint'({e.last, e.pad, e.data[23:0]}));
        end
      end
      if (err_len) dut_el++;
      if (err_oversize) dut_eo++;
      if (in_val && in_rdy) model_beat(in_startframe, in_endframe, in_frame_size, in_padbytes, in_data);
      hold_prev = out_val && !out_rdy;
      hold_data = out_data;
      hold_last = out_last;
      hold_pad  = out_padbytes;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_out) out_rdy = ($urandom_range(0, 99) < 85);
  endtask

  task automatic send_beat(input bit sof, input bit eof, input logic [SIZE_W-1:0] size,
                           input logic [PADBYTES_W-1:0] pad, input int gap_pct);
    int waited;
    int gaps;
    gaps = 0;
    while (gap_pct > 0 && gaps < 8 && $urandom_range(0, 99) < gap_pct) begin
      tick();
      gaps++;
    end
    in_val        = 1'b1;
    in_startframe = sof;
    in_endframe   = eof;
    in_frame_size = sof ? size : SIZE_W'($urandom);
    in_padbytes   = eof ? pad : PADBYTES_W'($urandom);
    in_data       = rand_data();
    waited = 0;
    while (!in_rdy && waited < 1000) begin
      tick();
      waited++;
    end
    if (!in_rdy) check(1'b0, "in_rdy_timeout", 0, 1);
    tick();
    in_val        = 1'b0;
    in_startframe = 1'b0;
    in_endframe   = 1'b0;
  endtask

  task automatic send_frame(input int nb, input bit no_sof, input int size, input int pad,
                            input int gap_pct);
    for (int b = 0; b < nb; b++) begin
      send_beat((b == 0) && !no_sof, b == nb - 1, SIZE_W'(size), PADBYTES_W'(pad), gap_pct);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_val) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check(1'b0, "drain_timeout", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[10];
    int   o0, l0, v0;
    int   kind, nb, pad, sz;

    tbl[0] = '{3,  1'b0, 130,  62, 3,  0, 0, "good_3b"};
    tbl[1] = '{3,  1'b0, 130,  10, 0,  1, 0, "bad_len_3b"};
    tbl[2] = '{1,  1'b0, 64,   0,  1,  0, 0, "good_1b"};
    tbl[3] = '{1,  1'b0, 1,    63, 1,  0, 0, "min_1b"};
    tbl[4] = '{32, 1'b0, 2048, 0,  32, 0, 0, "max_32b"};
    tbl[5] = '{33, 1'b0, 2112, 0,  0,  0, 1, "ovs_33b"};
    tbl[6] = '{40, 1'b0, 2560, 0,  0,  0, 1, "ovs_40b"};
    tbl[7] = '{2,  1'b0, 100,  28, 2,  0, 0, "good_2b"};
    tbl[8] = '{2,  1'b0, 100,  27, 0,  1, 0, "bad_len_2b"};
    tbl[9] = '{2,  1'b1, 0,    0,  0,  2, 0, "orphan_2b"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check(in_rdy == 1'b0, "rst_in_rdy", in_rdy, 0);
    check(out_val == 1'b0, "rst_out_val", out_val, 0);
    check(out_last == 1'b0, "rst_out_last", out_last, 0);
    check(out_padbytes == '0, "rst_out_pad", out_padbytes, 0);
    check(err_len == 1'b0, "rst_err_len", err_len, 0);
    check(err_oversize == 1'b0, "rst_err_ovs", err_oversize, 0);
    rst_n = 1'b1;
    #1;
    check(in_rdy == 1'b0, "rel_in_rdy_0", in_rdy, 0);
    tick();
    check(in_rdy == 1'b1, "rel_in_rdy_1", in_rdy, 1);

    // Table-driven frames
    out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      o0 = n_out; l0 = dut_el; v0 = dut_eo;
      send_frame(tbl[i].nb, tbl[i].no_sof, tbl[i].size, tbl[i].pad, 0);
      wait_idle();
      check(n_out - o0 == tbl[i].e_out, {tbl[i].name, "_beats"}, n_out - o0, tbl[i].e_out);
      check(dut_el - l0 == tbl[i].e_el, {tbl[i].name, "_err_len"}, dut_el - l0, tbl[i].e_el);
      check(dut_eo - v0 == tbl[i].e_eo, {tbl[i].name, "_err_ovs"}, dut_eo - v0, tbl[i].e_eo);
    end

    // Latency and back-to-back output of a 3-beat frame
    l0 = dut_el;
    send_beat(1'b1, 1'b0, 16'd130, 6'd0, 0);
    send_beat(1'b0, 1'b0, 16'd0, 6'd0, 0);
    send_beat(1'b0, 1'b1, 16'd0, 6'd62, 0);
    check(out_val == 1'b0, "lat_t1_val", out_val, 0);
    tick();
    check(out_val == 1'b1 && out_last == 1'b0, "lat_t2_beat1", {out_val, out_last}, 2);
    tick();
    check(out_val == 1'b1 && out_last == 1'b0, "lat_t3_beat2", {out_val, out_last}, 2);
    tick();
    check(out_val == 1'b1 && out_last == 1'b1 && out_padbytes == 6'd62, "lat_t4_beat3",
          {out_val, out_last, out_padbytes}, {2'b11, 6'd62});
    tick();
    check(out_val == 1'b0, "lat_t5_idle", out_val, 0);
    wait_idle();
    check(dut_el == l0, "lat_no_err", dut_el - l0, 0);

    // Truncated frame followed by an intact one
    o0 = n_out; l0 = dut_el;
    send_beat(1'b1, 1'b0, 16'd192, 6'd0, 0);
    send_beat(1'b0, 1'b0, 16'd0, 6'd0, 0);
    send_frame(2, 1'b0, 128, 0, 0);
    wait_idle();
    check(dut_el - l0 == 1, "trunc_err_len", dut_el - l0, 1);
    check(n_out - o0 == 2, "trunc_beats", n_out - o0, 2);

    // Oversize pulse timing and in_rdy while dropping
    o0 = n_out;
    for (int b = 0; b < 32; b++) send_beat(b == 0, 1'b0, 16'd2560, 6'd0, 0);
    check(err_oversize == 1'b0, "ovs_b32_quiet", err_oversize, 0);
    send_beat(1'b0, 1'b0, 16'd0, 6'd0, 0);
    check(err_oversize == 1'b1, "ovs_b33_pulse", err_oversize, 1);
    for (int b = 34; b <= 40; b++) begin
      check(in_rdy == 1'b1, "ovs_drop_in_rdy", in_rdy, 1);
      send_beat(1'b0, b == 40, 16'd0, 6'd0, 0);
      if (b == 34) check(err_oversize == 1'b0, "ovs_one_cycle", err_oversize, 0);
    end
    wait_idle();
    check(n_out == o0, "ovs_no_out", n_out - o0, 0);
    send_frame(2, 1'b0, 120, 8, 0);
    wait_idle();
    check(n_out - o0 == 2, "ovs_next_frame", n_out - o0, 2);

    // Fill to full under backpressure, then drain; repeated for pointer wraparound
    for (int p = 0; p < 3; p++) begin
      o0 = n_out;
      out_rdy = 1'b0;
      for (int f = 0; f < 16; f++) send_frame(4, 1'b0, 256, 0, 0);
      check(in_rdy == 1'b0, "full_in_rdy", in_rdy, 0);
      tick();
      tick();
      check(in_rdy == 1'b0 && out_val == 1'b1, "full_hold", {in_rdy, out_val}, 1);
      out_rdy = 1'b1;
      wait_idle();
      check(n_out - o0 == 64, "full_drain_beats", n_out - o0, 64);
    end

    // Async reset while beat 2 of a frame is on the output
    send_frame(3, 1'b0, 192, 0, 0);
    begin
      int n;
      n = 0;
      while (!out_val && n < 20) begin
        tick();
        n++;
      end
    end
    tick();
    check(out_val == 1'b1, "rstmid_pre_val", out_val, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check(out_val == 1'b0 && out_last == 1'b0, "rstmid_out_val", {out_val, out_last}, 0);
    check(in_rdy == 1'b0, "rstmid_in_rdy", in_rdy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check(in_rdy == 1'b0, "rstmid_rel_0", in_rdy, 0);
    tick();
    check(in_rdy == 1'b1, "rstmid_rel_1", in_rdy, 1);
    for (int k = 0; k < 4; k++) begin
      check(out_val == 1'b0, "rstmid_empty", out_val, 0);
      tick();
    end
    o0 = n_out;
    send_frame(2, 1'b0, 70, 58, 0);
    wait_idle();
    check(n_out - o0 == 2, "rstmid_next_frame", n_out - o0, 2);

    // Random traffic against the model
    rnd_out = 1'b1;
    for (int f = 0; f < 250; f++) begin
      kind = $urandom_range(0, 99);
      if (kind < 70) begin
        nb  = $urandom_range(1, MAX_BEATS);
        pad = $urandom_range(0, BYTES - 1);
        send_frame(nb, 1'b0, nb * BYTES - pad, pad, 30);
      end else if (kind < 80) begin
        nb  = $urandom_range(1, MAX_BEATS);
        pad = $urandom_range(0, BYTES - 1);
        sz  = nb * BYTES - pad + $urandom_range(1, 64);
        send_frame(nb, 1'b0, sz, pad, 30);
      end else if (kind < 88) begin
        nb = $urandom_range(MAX_BEATS + 1, MAX_BEATS + 8);
        send_frame(nb, 1'b0, nb * BYTES, 0, 30);
      end else if (kind < 94) begin
        nb = $urandom_range(1, 5);
        for (int b = 0; b < nb; b++) send_beat(b == 0, 1'b0, SIZE_W'(nb * BYTES), '0, 30);
      end else begin
        send_beat(1'b0, 1'($urandom_range(0, 1)), '0, '0, 30);
      end
    end
    rnd_out = 1'b0;
    out_rdy = 1'b1;
    wait_idle();
    check(dut_el == exp_el, "rand_err_len_total", dut_el, exp_el);
    check(dut_eo == exp_eo, "rand_err_ovs_total", dut_eo, exp_eo);
    check(exp_q.size() == 0, "rand_all_emitted", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
